// File: rtl/joy_pkg.sv
// Shared types and default tuning for the joystick cursor controller.
package joy_pkg;

    typedef enum logic [2:0] {DEAD, LO_SLOW, LO_FAST, HI_SLOW, HI_FAST} zone_t;
    typedef enum logic [1:0] {IDLE, SLOW, FAST, TURBO} axis_st_t;

    localparam int TH_LO_FAST_DEF  = 150;
    localparam int TH_LO_SLOW_DEF  = 400;
    localparam int TH_HI_SLOW_DEF  = 600;
    localparam int TH_HI_FAST_DEF  = 850;
    localparam int STEP_SLOW_DEF   = 10;
    localparam int STEP_FAST_DEF   = 20;
    localparam int STEP_TURBO_DEF  = 40;
    localparam int ACCEL_TICKS_DEF = 8;

endpackage

// File: rtl/joy_cursor_ctl_if.sv
// Control inputs and cursor/status outputs of the cursor controller.
interface joy_cursor_ctl_if #(
    parameter int POS_W = 10,
    parameter int ADC_W = 10
);
    logic             en;
    logic             home;
    logic [ADC_W-1:0] joy_x;
    logic [ADC_W-1:0] joy_y;
    logic [POS_W-1:0] dot_x;
    logic [POS_W-1:0] dot_y;
    logic             moved;
    logic [3:0]       at_edge;

    modport master (output en, home, joy_x, joy_y,
                    input  dot_x, dot_y, moved, at_edge);
    modport slave  (input  en, home, joy_x, joy_y,
                    output dot_x, dot_y, moved, at_edge);
endinterface

// File: rtl/joy_axis.sv
// One cursor axis: zone classification, acceleration FSM, step and clamp.
module joy_axis
    import joy_pkg::*;
#(
    parameter int POS_W       = 10,
    parameter int ADC_W       = 10,
    parameter bit INVERT      = 1'b0,
    parameter int MIN         = 0,
    parameter int MAX         = 1023,
    parameter int INIT        = 0,
    parameter int TH_LO_FAST  = TH_LO_FAST_DEF,
    parameter int TH_LO_SLOW  = TH_LO_SLOW_DEF,
    parameter int TH_HI_SLOW  = TH_HI_SLOW_DEF,
    parameter int TH_HI_FAST  = TH_HI_FAST_DEF,
    parameter int STEP_SLOW   = STEP_SLOW_DEF,
    parameter int STEP_FAST   = STEP_FAST_DEF,
    parameter int STEP_TURBO  = STEP_TURBO_DEF,
    parameter int ACCEL_TICKS = ACCEL_TICKS_DEF
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             adv,      // registered tick edge
    input  logic             en,
    input  logic             home,
    input  logic [ADC_W-1:0] s,
    output logic [POS_W-1:0] pos,
    output logic [POS_W-1:0] pos_nxt
);

    localparam int HW = $clog2(ACCEL_TICKS + 1);
    localparam int SW = POS_W + 2;
    typedef logic signed [SW-1:0] sval_t;
    localparam sval_t MIN_S = sval_t'(MIN);
    localparam sval_t MAX_S = sval_t'(MAX);

    zone_t         zone, zone_q;
    axis_st_t      st, st_nxt;
    logic [HW-1:0] hold, hold_nxt;
    sval_t         step, base, sum;
    logic          plus, fast, same_fast;

    // Classify the sample into one of five zones (strict compares)
    always_comb begin
        zone = DEAD;
        if      (s < ADC_W'(TH_LO_FAST)) zone = LO_FAST;
        else if (s < ADC_W'(TH_LO_SLOW)) zone = LO_SLOW;
        else if (s > ADC_W'(TH_HI_FAST)) zone = HI_FAST;
        else if (s > ADC_W'(TH_HI_SLOW)) zone = HI_SLOW;
    end

    assign plus      = ((zone == LO_SLOW) || (zone == LO_FAST)) ^ INVERT;
    assign fast      = (zone == LO_FAST) || (zone == HI_FAST);
    // Acceleration only continues in the very same fast zone; a reversal
    // lands in the opposite fast zone and so restarts at FAST.
    assign same_fast = fast && (zone == zone_q) && ((st == FAST) || (st == TURBO));

    // Next state, hold count and step for the state being entered
    always_comb begin
        st_nxt   = st;
        hold_nxt = hold;
        step     = '0;
        if (home || !en) begin
            st_nxt   = IDLE;
            hold_nxt = '0;
        end else if (adv) begin
            if (zone == DEAD) begin
                st_nxt   = IDLE;
                hold_nxt = '0;
            end else if (!fast) begin
                st_nxt   = SLOW;
                hold_nxt = '0;
                step     = sval_t'(STEP_SLOW);
            end else if (!same_fast) begin
                st_nxt   = FAST;
                hold_nxt = HW'(1);
                step     = sval_t'(STEP_FAST);
            end else if (st == TURBO) begin
                step     = sval_t'(STEP_TURBO);
            end else if (({1'b0, hold} + (HW+1)'(1)) >= (HW+1)'(ACCEL_TICKS)) begin
                st_nxt   = TURBO;
                hold_nxt = HW'(ACCEL_TICKS);
                step     = sval_t'(STEP_TURBO);
            end else begin
                st_nxt   = FAST;
                hold_nxt = hold + HW'(1);
                step     = sval_t'(STEP_FAST);
            end
        end
    end

    // Signed step with two guard bits so pos - step < 0 clamps instead of wrapping.
    // An edge that lands in IDLE applies no step and leaves the position alone.
    always_comb begin
        base    = sval_t'({2'b00, pos});
        sum     = plus ? (base + step) : (base - step);
        pos_nxt = pos;
        if (home) begin
            pos_nxt = POS_W'(INIT);
        end else if (en && adv && (st_nxt != IDLE)) begin
            if      (sum < MIN_S) pos_nxt = POS_W'(MIN);
            else if (sum > MAX_S) pos_nxt = POS_W'(MAX);
            else                  pos_nxt = sum[POS_W-1:0];
        end
    end

    // Axis state registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            st     <= IDLE;
            hold   <= '0;
            zone_q <= DEAD;
            pos    <= POS_W'(INIT);
        end else begin
            st   <= st_nxt;
            hold <= hold_nxt;
            pos  <= pos_nxt;
            if (adv) zone_q <= zone;
        end
    end

endmodule

// File: rtl/joy_cursor_ctl.sv
// Two-axis joystick cursor controller: tick edge, home/enable, status.
module joy_cursor_ctl
    import joy_pkg::*;
#(
    parameter int POS_W       = 10,
    parameter int ADC_W       = 10,
    parameter int INIT_X      = 234,
    parameter int INIT_Y      = 271,
    parameter int X_MIN       = 239,
    parameter int X_MAX       = 362,
    parameter int Y_MIN       = 116,
    parameter int Y_MAX       = 426,
    parameter int TH_LO_FAST  = TH_LO_FAST_DEF,
    parameter int TH_LO_SLOW  = TH_LO_SLOW_DEF,
    parameter int TH_HI_SLOW  = TH_HI_SLOW_DEF,
    parameter int TH_HI_FAST  = TH_HI_FAST_DEF,
    parameter int STEP_SLOW   = STEP_SLOW_DEF,
    parameter int STEP_FAST   = STEP_FAST_DEF,
    parameter int STEP_TURBO  = STEP_TURBO_DEF,
    parameter int ACCEL_TICKS = ACCEL_TICKS_DEF
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic            tick,
    joy_cursor_ctl_if.slave bus
);

    logic             tick_q, edge_q, moved;
    logic [POS_W-1:0] x_pos, x_nxt, y_pos, y_nxt;

    // Rising-edge detect on the raw tick; tick_q resets high so a tick
    // already high at reset release is not taken as an edge.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            tick_q <= 1'b1;
            edge_q <= 1'b0;
        end else begin
            tick_q <= tick;
            edge_q <= tick & ~tick_q;
        end
    end

    joy_axis #(
        .POS_W(POS_W), .ADC_W(ADC_W), .INVERT(1'b0),
        .MIN(X_MIN), .MAX(X_MAX), .INIT(INIT_X),
        .TH_LO_FAST(TH_LO_FAST), .TH_LO_SLOW(TH_LO_SLOW),
        .TH_HI_SLOW(TH_HI_SLOW), .TH_HI_FAST(TH_HI_FAST),
        .STEP_SLOW(STEP_SLOW), .STEP_FAST(STEP_FAST),
        .STEP_TURBO(STEP_TURBO), .ACCEL_TICKS(ACCEL_TICKS)
    ) u_x (
        .clk(clk), .clr_n(clr_n), .adv(edge_q), .en(bus.en), .home(bus.home),
        .s(bus.joy_x), .pos(x_pos), .pos_nxt(x_nxt)
    );

    joy_axis #(
        .POS_W(POS_W), .ADC_W(ADC_W), .INVERT(1'b1),
        .MIN(Y_MIN), .MAX(Y_MAX), .INIT(INIT_Y),
        .TH_LO_FAST(TH_LO_FAST), .TH_LO_SLOW(TH_LO_SLOW),
        .TH_HI_SLOW(TH_HI_SLOW), .TH_HI_FAST(TH_HI_FAST),
        .STEP_SLOW(STEP_SLOW), .STEP_FAST(STEP_FAST),
        .STEP_TURBO(STEP_TURBO), .ACCEL_TICKS(ACCEL_TICKS)
    ) u_y (
        .clk(clk), .clr_n(clr_n), .adv(edge_q), .en(bus.en), .home(bus.home),
        .s(bus.joy_y), .pos(y_pos), .pos_nxt(y_nxt)
    );

    // moved pulses in the cycle the new position becomes visible
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) moved <= 1'b0;
        else        moved <= (x_nxt != x_pos) || (y_nxt != y_pos);
    end

    assign bus.dot_x   = x_pos;
    assign bus.dot_y   = y_pos;
    assign bus.moved   = moved;
    assign bus.at_edge = {y_pos == POS_W'(Y_MAX), y_pos == POS_W'(Y_MIN),
                          x_pos == POS_W'(X_MAX), x_pos == POS_W'(X_MIN)};

endmodule

// File: tb/tb_joy_cursor_ctl.sv
// Scoreboard bench for joy_cursor_ctl with a behavioural cursor model.
module tb_joy_cursor_ctl;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    logic tick = 1'b0;

    joy_cursor_ctl_if #(.POS_W(10), .ADC_W(10)) bus ();

    joy_cursor_ctl dut (.clk(clk), .clr_n(clr_n), .tick(tick), .bus(bus.slave));

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    typedef struct {int x; int y; int mv;} exp_t;
    exp_t sb[$];

    // model state per axis (0=x, 1=y); states 0 idle,1 slow,2 fast,3 turbo
    int mpos[2], mst[2], mhold[2], mzone[2];

    function automatic int zone_of(input int s);
        if (s < 150) return 2;        // lo fast
        if (s < 400) return 1;        // lo slow
        if (s > 850) return 4;        // hi fast
        if (s > 600) return 3;        // hi slow
        return 0;
    endfunction

    task automatic model_reset();
        mpos[0] = 234; mpos[1] = 271;
        for (int a = 0; a < 2; a++) begin mst[a] = 0; mhold[a] = 0; mzone[a] = 0; end
    endtask

    task automatic model_idle();
        for (int a = 0; a < 2; a++) begin mst[a] = 0; mhold[a] = 0; end
    endtask

    task automatic model_axis(input int a, input int s, input bit inv, input int mn, input int mx);
        int z, step;
        bit lo;
        z = zone_of(s);
        step = 0;
        if (z == 0) begin
            mst[a] = 0; mhold[a] = 0;
        end else if (z == 1 || z == 3) begin
            mst[a] = 1; mhold[a] = 0; step = 10;
        end else if ((mst[a] == 2 || mst[a] == 3) && z == mzone[a]) begin
            if (mst[a] == 2) mhold[a]++;
            if (mhold[a] >= 8) begin mst[a] = 3; step = 40; end
            else step = 20;
        end else begin
            mst[a] = 2; mhold[a] = 1; step = 20;
        end
        mzone[a] = z;
        if (step != 0) begin
            lo = (z == 1 || z == 2);
            mpos[a] = mpos[a] + ((lo ^ inv) ? step : -step);
            if (mpos[a] < mn) mpos[a] = mn;
            if (mpos[a] > mx) mpos[a] = mx;
        end
    endtask

    // one tick edge (or home) applied to the model, result pushed to the scoreboard
    task automatic model_edge(input bit do_home);
        exp_t e;
        int ox, oy;
        ox = mpos[0]; oy = mpos[1];
        if (do_home) begin
            mpos[0] = 234; mpos[1] = 271; model_idle();
        end else if (!bus.en) begin
            model_idle();
        end else begin
            model_axis(0, int'(bus.joy_x), 1'b0, 239, 362);
            model_axis(1, int'(bus.joy_y), 1'b1, 116, 426);
        end
        e.x = mpos[0]; e.y = mpos[1];
        e.mv = (ox != mpos[0]) || (oy != mpos[1]);
        sb.push_back(e);
    endtask

    function automatic int exp_edge();
        return {28'd0, mpos[1] == 426, mpos[1] == 116, mpos[0] == 362, mpos[0] == 239};
    endfunction

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_x"}, int'(bus.dot_x), e.x);
        chk({tag, "_y"}, int'(bus.dot_y), e.y);
        chk({tag, "_moved"}, int'(bus.moved), e.mv);
    endtask

    // drive a tick pulse high for 1+hi_cyc samples; optionally collide with home
    task automatic tick_pulse(input string tag, input int hi_cyc, input bit collide);
        int seen;
        @(negedge clk); tick = 1'b1;
        @(posedge clk);
        if (collide) begin @(negedge clk); bus.home = 1'b1; end
        model_edge(collide);
        @(posedge clk); #1;
        pop_check(tag);
        bus.home = 1'b0;
        seen = 0;
        for (int i = 0; i < hi_cyc; i++) begin
            @(posedge clk); #1;
            if (bus.moved) seen++;
        end
        chk({tag, "_extra_moves"}, seen, 0);
        chk({tag, "_hold_x"}, int'(bus.dot_x), mpos[0]);
        chk({tag, "_hold_y"}, int'(bus.dot_y), mpos[1]);
        @(negedge clk); tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_home(input string tag);
        @(negedge clk); bus.home = 1'b1;
        model_edge(1'b1);
        @(posedge clk); #1;
        pop_check(tag);
        bus.home = 1'b0;
    endtask

    initial begin
        int seen;
        bus.en = 1'b1; bus.home = 1'b0; bus.joy_x = 10'd512; bus.joy_y = 10'd512;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x", int'(bus.dot_x), 234);
        chk("rst_y", int'(bus.dot_y), 271);
        chk("rst_moved", int'(bus.moved), 0);
        chk("rst_edge", int'(bus.at_edge), 0);
        @(negedge clk); clr_n = 1'b1;
        repeat (2) @(negedge clk);

        // first tick: x fast +20, y dead
        bus.joy_x = 10'd100; bus.joy_y = 10'd512;
        tick_pulse("first", 1, 1'b0);

        // slow y step, tick held high for 50 clocks
        bus.joy_x = 10'd512; bus.joy_y = 10'd300;
        tick_pulse("held", 50, 1'b0);

        // drive x up to X_MAX, then accelerate down into X_MIN
        bus.joy_y = 10'd512; bus.joy_x = 10'd100;
        for (int i = 0; i < 6; i++) tick_pulse("to_max", 1, 1'b0);
        chk("edge_xmax", int'(bus.at_edge), exp_edge());
        bus.joy_x = 10'd900;
        for (int i = 0; i < 10; i++) tick_pulse("accel", 1, 1'b0);
        chk("edge_xmin", int'(bus.at_edge), exp_edge());

        // reversal out of TURBO restarts at FAST
        bus.joy_x = 10'd100;
        tick_pulse("reverse", 1, 1'b0);
        bus.joy_x = 10'd300;
        tick_pulse("slow_x", 1, 1'b0);

        // home collides with a tick edge: edge consumed
        bus.joy_x = 10'd100; bus.joy_y = 10'd900;
        tick_pulse("collide", 1, 1'b1);
        do_home("home_again");

        // y accelerates downward into Y_MIN
        bus.joy_x = 10'd512; bus.joy_y = 10'd100;
        for (int i = 0; i < 9; i++) tick_pulse("y_down", 1, 1'b0);
        chk("edge_ymin", int'(bus.at_edge), exp_edge());

        // disabled: edges ignored
        bus.en = 1'b0; bus.joy_x = 10'd100; bus.joy_y = 10'd900;
        for (int i = 0; i < 3; i++) tick_pulse("disabled", 1, 1'b0);
        bus.en = 1'b1;

        // asynchronous reset between ticks, tick high at release
        @(posedge clk); #2 clr_n = 1'b0;
        #1;
        model_reset();
        chk("async_x", int'(bus.dot_x), 234);
        chk("async_y", int'(bus.dot_y), 271);
        chk("async_moved", int'(bus.moved), 0);
        tick = 1'b1;
        @(negedge clk); clr_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.moved) seen++;
        end
        chk("rel_moves", seen, 0);
        chk("rel_x", int'(bus.dot_x), 234);
        @(negedge clk); tick = 1'b0;
        @(negedge clk);
        tick_pulse("after_rst", 1, 1'b0);

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/joy_cursor_ctl.md
# joy_cursor_ctl

Parametrised two-axis joystick cursor controller. It converts 10-bit ADC joystick readings into a bounded screen cursor position (dot_x, dot_y) for the VGA renderer, once per rising edge of the slow cursor tick. Compared with the previous single-purpose updater, it adds:
- internal tick edge detection;
- saturating clamp to the play area (no overshoot);
- a per-axis acceleration state machine;
- enable and home controls;
- status outputs.

## Interface
Parameters:
- POS_W, 10, cursor coordinate width
- ADC_W, 10, joystick sample width
- INIT_X, 234 / INIT_Y, 271, position after reset or home
- X_MIN, 239 / X_MAX, 362 / Y_MIN, 116 / Y_MAX, 426, inclusive clamp bounds
- TH_LO_FAST, 150 / TH_LO_SLOW, 400 / TH_HI_SLOW, 600 / TH_HI_FAST, 850, zone thresholds
- STEP_SLOW, 10 / STEP_FAST, 20 / STEP_TURBO, 40, step sizes in pixels
- ACCEL_TICKS, 8, consecutive fast-zone ticks before turbo (≥1)

Ports:
- clk  in  1  system clock
- clr_n  in  1  reset; one clock; reset is asynchronous and active-low
- tick  in  1  raw cursor-rate clock, level sampled on clk
- en  in  1  movement enable
- home  in  1  synchronous request to return to INIT_X/INIT_Y
- joy_x  in  ADC_W  X ADC sample
- joy_y  in  ADC_W  Y ADC sample
- dot_x  out  POS_W  cursor X
- dot_y  out  POS_W  cursor Y
- moved  out  1  one-cycle pulse when either coordinate changed
- at_edge  out  4  {y_max, y_min, x_max, x_min}; each bit set while the coordinate equals that bound

## Operation
- Tick edge: tick_q is registered from tick. tick_edge = tick & ~tick_q. tick_q resets to 1, so a tick that is high at reset release produces no edge.
- Zone classification per axis, from sample s (strict compares):
  - s < TH_LO_FAST → LO_FAST
  - s < TH_LO_SLOW → LO_SLOW
  - s > TH_HI_FAST → HI_FAST
  - s > TH_HI_SLOW → HI_SLOW
  - otherwise DEAD
- Direction:
  - X: LO zones → +, HI zones → −.
  - Y: LO zones → −, HI zones → +.
- Per-axis FSM, advancing only on tick_edge with en=1:
  - IDLE: DEAD → IDLE. Slow zone → SLOW. Fast zone → FAST with hold_cnt=1.
  - SLOW: step STEP_SLOW. Next state follows the zone as in IDLE.
  - FAST: step STEP_FAST. Same fast zone → hold_cnt+1; on reaching ACCEL_TICKS → TURBO. Other zone → re-enter per the IDLE rules.
  - TURBO: step STEP_TURBO while the same fast zone persists. Any other zone → re-enter per the IDLE rules.
  - A change of direction always restarts acceleration.
- The step applied on an edge is the one for the state being entered.
- Arithmetic: next = pos ± step, computed at POS_W+2 bits signed, then clamped to [MIN, MAX]. The result never wraps, including for pos − step < 0.
- en=0: edges are ignored, both FSMs go to IDLE, hold_cnt clears, position holds.
- home=1: position loads INIT_X/INIT_Y and FSMs go to IDLE. home has priority over a simultaneous tick_edge, and that edge is consumed.
- moved asserts only if the new value differs from the old one. Clamped no-op steps and home when already at INIT give moved=0.

## Timing
- Reset values:
  - dot_x=INIT_X, dot_y=INIT_Y
  - moved=0
  - at_edge reflects the INIT position (0 for the defaults)
  - FSMs IDLE, hold_cnt=0, tick_q=1
- Latency: tick is sampled high at clk edge k with tick_q=0 → dot_x/dot_y/moved update at edge k+1. moved is high for exactly one cycle.
- home sampled at edge k → position is INIT after edge k.
- at_edge is combinational from the registered position and has no extra latency.
- A tick held high for many clk cycles produces one update. Re-arming requires tick low for at least one clk sample.
- Reset asserted mid-operation immediately forces all reset values, regardless of clk.

## Structure
- Package joy_pkg:
  - zone_t enum {DEAD, LO_SLOW, LO_FAST, HI_SLOW, HI_FAST}
  - axis_st_t enum {IDLE, SLOW, FAST, TURBO}
  - default threshold and step constants
- Sub-module joy_axis, instantiated twice. It contains zone classification, the FSM, hold_cnt, step selection and the clamp. Its parameters are INVERT (Y=1), MIN, MAX and INIT.
- Top level holds tick_q, the home/en gating, moved and at_edge.

## Test plan
- Reset and first tick: reset, joy_x=100, joy_y=512, one tick pulse → dot_x=254, dot_y=271, moved one cycle.
- Slow step and no repeat on a held tick: joy_y=300, tick held high 50 clk → dot_y=261 (single step).
- Acceleration: joy_x=900 held, 10 ticks from x=362 → FAST steps on ticks 1–7, TURBO from tick 8. dot_x clamps at 239, at_edge[0]=1, and moved=0 on clamped no-op ticks.
- Direction reversal: while in TURBO, switch joy_x to 100 → next step is +20 and hold_cnt restarts.
- home/tick collision: home and a tick edge in the same cycle at (300,200) → (234,271), no step applied.
- Enable and reset mid-move: en=0 with joy_x=100 ticking → no change. clr_n low between ticks → INIT values immediately, tick high at release → no movement.
